instr_fetch_unit: RTL and testbench

//   Upstream instruction source for the processor: holds a DEPTH x 8 program store,

---
 rtl/instr_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: a DEPTH x DATA_W program store that is filled through a
// valid/ready load port and then serves registered opcodes addressed by the processor's
// program counter. Fetching HLT_OP freezes the output until the next load or reset.
module instr_fetch_unit #(
    parameter int unsigned         DEPTH  = 16,
    parameter int unsigned         ADDR_W = 4,
    parameter int unsigned         DATA_W = 8,
    parameter logic [DATA_W-1:0]   NOP_OP = 8'h00,
    parameter logic [DATA_W-1:0]   HLT_OP = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    input  logic              run,
    input  logic [ADDR_W-1:0] program_counter,
    output logic [DATA_W-1:0] opcode,
    output logic              opcode_valid,
    output logic              halted,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLoad = 2'b01,
        StRun  = 2'b10,
        StHalt = 2'b11
    } state_e;

    localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                load_ready_q, load_ready_d;
    logic                load_done_q, load_done_d;
    logic                halted_q, halted_d;
    logic [DATA_W-1:0]   opcode_q, opcode_d;
    logic                opcode_valid_q, opcode_valid_d;

    logic                xfer;
    logic                final_word;
    logic [DATA_W-1:0]   fetch_word;

    // Load handshake qualifiers and the store word at the current fetch address.
    always_comb begin
        xfer       = (state_q == StLoad) && load_valid && load_ready_q;
        final_word = xfer && (load_last || (ptr_q == LastPtr));
        fetch_word = mem_q[program_counter];
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; load_start overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (load_start) begin
            state_d = StLoad;
        end else begin
            unique case (state_q)
                StIdle: if (run && load_done_q) state_d = StRun;
                StLoad: if (final_word) state_d = StIdle;
                StRun:  if (fetch_word == HLT_OP) state_d = StHalt;
                StHalt: state_d = StHalt;
                default: state_d = StIdle;
            endcase
        end
    end

    // Next-state for the store, load pointer and registered outputs.
    always_comb begin
        mem_d          = mem_q;
        ptr_d          = ptr_q;
        load_ready_d   = load_ready_q;
        load_done_d    = load_done_q;
        halted_d       = halted_q;
        opcode_d       = opcode_q;
        opcode_valid_d = opcode_valid_q;
        if (load_start) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = NOP_OP;
            end
            ptr_d          = '0;
            load_ready_d   = 1'b1;
            load_done_d    = 1'b0;
            halted_d       = 1'b0;
            opcode_d       = NOP_OP;
            opcode_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (xfer) begin
                        mem_d[ptr_q] = load_data;
                        if (final_word) begin
                            // Pointer is left in place so it never wraps past the last word.
                            load_ready_d = 1'b0;
                            load_done_d  = 1'b1;
                        end else begin
                            ptr_d = ptr_q + ADDR_W'(1);
                        end
                    end
                end
                StRun: begin
                    opcode_d       = fetch_word;
                    opcode_valid_d = 1'b1;
                    if (fetch_word == HLT_OP) begin
                        halted_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers; reset empties the store and discards any partial load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= NOP_OP;
            end
            ptr_q          <= '0;
            load_ready_q   <= 1'b0;
            load_done_q    <= 1'b0;
            halted_q       <= 1'b0;
            opcode_q       <= NOP_OP;
            opcode_valid_q <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            ptr_q          <= ptr_d;
            load_ready_q   <= load_ready_d;
            load_done_q    <= load_done_d;
            halted_q       <= halted_d;
            opcode_q       <= opcode_d;
            opcode_valid_q <= opcode_valid_d;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        state        = state_q;
        load_ready   = load_ready_q;
        load_done    = load_done_q;
        halted       = halted_q;
        opcode       = opcode_q;
        opcode_valid = opcode_valid_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: load, run, halt, full-store load and
// reset-during-load scenarios with hand-computed expectations.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start;
    logic [7:0] load_data;
    logic       load_valid;
    logic       load_last;
    logic       load_ready;
    logic       load_done;
    logic       run;
    logic [3:0] program_counter;
    logic [7:0] opcode;
    logic       opcode_valid;
    logic       halted;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .load_start      (load_start),
        .load_data       (load_data),
        .load_valid      (load_valid),
        .load_last       (load_last),
        .load_ready      (load_ready),
        .load_done       (load_done),
        .run             (run),
        .program_counter (program_counter),
        .opcode          (opcode),
        .opcode_valid    (opcode_valid),
        .halted          (halted),
        .state           (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        load_data  = d;
        load_valid = 1'b1;
        load_last  = last;
        cyc();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [3:0] pc, input logic [7:0] exp, input string tag);
        program_counter = pc;
        cyc();
        check(tag, opcode, exp);
        check({tag, "_valid"}, opcode_valid, 1);
    endtask

    initial begin
        reset           = 1'b0;
        load_start      = 1'b0;
        load_data       = 8'h00;
        load_valid      = 1'b0;
        load_last       = 1'b0;
        run             = 1'b0;
        program_counter = 4'h0;

        // 1) reset state
        cyc();
        cyc();
        check("rst_opcode", opcode, 8'h00);
        check("rst_state", state, 2'b00);
        check("rst_ready", load_ready, 0);
        check("rst_done", load_done, 0);
        check("rst_halted", halted, 0);
        check("rst_valid", opcode_valid, 0);
        reset = 1'b1;
        cyc();

        // 2) small program with a gap before the last word
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        check("ld_state", state, 2'b01);
        check("ld_ready", load_ready, 1);
        send(8'h91, 1'b0);
        send(8'h15, 1'b0);
        cyc();
        check("ld_gap_done", load_done, 0);
        send(8'hFF, 1'b1);
        check("ld_done", load_done, 1);
        check("ld_state_idle", state, 2'b00);
        check("ld_ready_low", load_ready, 0);

        // 3) run and fetch
        run = 1'b1;
        cyc();
        check("run_state", state, 2'b10);
        fetch(4'h0, 8'h91, "pc0");
        fetch(4'h1, 8'h15, "pc1");
        fetch(4'h3, 8'h00, "pc3_nop");
        fetch(4'hF, 8'h00, "pcF_nop");

        // 4) halt
        fetch(4'h2, 8'hFF, "pc2_hlt");
        check("hlt_halted", halted, 1);
        check("hlt_state", state, 2'b11);
        fetch(4'h3, 8'hFF, "hlt_frozen");
        check("hlt_state_hold", state, 2'b11);

        // 5) full 16-word store without load_last
        run        = 1'b0;
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        check("reld_halted", halted, 0);
        check("reld_state", state, 2'b01);
        check("reld_valid", opcode_valid, 0);
        check("reld_opcode", opcode, 8'h00);
        for (int i = 0; i < 16; i++) begin
            send(8'h10 + 8'(i), 1'b0);
            if (i == 14) begin
                check("full_done_early", load_done, 0);
                check("full_ready_early", load_ready, 1);
            end
        end
        check("full_done", load_done, 1);
        check("full_ready", load_ready, 0);
        check("full_state", state, 2'b00);
        send(8'hAA, 1'b0);
        check("extra_ignored_done", load_done, 1);
        run = 1'b1;
        cyc();
        fetch(4'hF, 8'h1F, "full_pcF");
        fetch(4'h0, 8'h10, "full_pc0");
        fetch(4'h7, 8'h17, "full_pc7");

        // 6) reset during a partial load
        run        = 1'b0;
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(8'h20 + 8'(i), 1'b0);
        end
        reset = 1'b0;
        #1;
        check("arst_state", state, 2'b00);
        check("arst_done", load_done, 0);
        check("arst_ready", load_ready, 0);
        cyc();
        reset = 1'b1;
        cyc();
        load_start = 1'b1;
        run        = 1'b1;
        cyc();
        load_start = 1'b0;
        run        = 1'b0;
        check("start_wins", state, 2'b01);
        send(8'h42, 1'b1);
        check("post_done", load_done, 1);
        run = 1'b1;
        cyc();
        fetch(4'h1, 8'h00, "post_pc1");
        fetch(4'h4, 8'h00, "post_pc4");
        fetch(4'h0, 8'h42, "post_pc0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
